// File: rtl/prog_sequencer.sv
// prog_sequencer: round-robin scheduler that picks the program image for the
// serial loader, requests the load, waits for completion, lets the program
// run, then advances. A debounced button forces an advance; a load watchdog
// raises a sticky error.
// Build option: define PROG_SEQ_AUTO_ADVANCE_EN to also advance automatically
// after DWELL_CYCLES un-paused run cycles; without it RUN exits only on a press.
module prog_sequencer #(
    parameter int unsigned NPROG        = 4,
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned DBNC_CYCLES  = 1_000_000,
    parameter int unsigned LOAD_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_next,
    input  logic                     pause,
    input  logic                     done_in,
    output logic                     drive_out,
    output logic [$clog2(NPROG)-1:0] prog_sel,
    output logic                     busy,
    output logic                     err
);
    localparam int unsigned SEL_W  = $clog2(NPROG);
    localparam int unsigned DBNC_W = $clog2(DBNC_CYCLES + 1);
    localparam int unsigned LOAD_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_NEXT,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [DBNC_W-1:0]   dbnc_cnt_q, dbnc_cnt_d;
    logic                filt_q, filt_d;
    logic                press_q, press_d;
    logic                pend_q, pend_d;
    logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
    logic [SEL_W-1:0]    prog_sel_q, prog_sel_d;
    logic                err_q, err_d;
    logic                load_expire;
    logic                dwell_done;

    // Button filter: the filtered level follows the synchronised level only
    // after DBNC_CYCLES consecutive samples disagreeing with it; a filtered
    // rising edge becomes a one-cycle press.
    always_comb begin
        dbnc_cnt_d = '0;
        filt_d     = filt_q;
        if (sync2_q != filt_q) begin
            if (dbnc_cnt_q == DBNC_W'(DBNC_CYCLES - 1)) begin
                filt_d = sync2_q;
            end else begin
                dbnc_cnt_d = dbnc_cnt_q + 1'b1;
            end
        end
        press_d = filt_d & ~filt_q;
    end

    // The counter is zero on every LOAD entry; the cycle that would make it
    // reach LOAD_TIMEOUT is the last LOAD cycle.
    assign load_expire = (load_cnt_q >= LOAD_W'(LOAD_TIMEOUT - 1));

`ifdef PROG_SEQ_AUTO_ADVANCE_EN
    localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES + 1);

    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;

    // Dwell counter: zero outside RUN, counts un-paused RUN cycles.
    always_comb begin
        dwell_cnt_d = '0;
        if (state_q == S_RUN) begin
            dwell_cnt_d = pause ? dwell_cnt_q : dwell_cnt_q + 1'b1;
        end
    end

    assign dwell_done = (state_q == S_RUN) && !pause &&
                        (dwell_cnt_q == DWELL_W'(DWELL_CYCLES - 1));

    // Dwell counter register.
    always_ff @(posedge clk) begin
        if (rst) dwell_cnt_q <= '0;
        else     dwell_cnt_q <= dwell_cnt_d;
    end
`else
    localparam int unsigned DWELL_UNUSED = DWELL_CYCLES;
    logic pause_unused;

    assign pause_unused = pause;
    assign dwell_done   = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    state_d = S_LOAD;
            S_LOAD: begin
                if (done_in)          state_d = S_RELEASE;
                else if (load_expire) state_d = S_FAULT;
            end
            S_RELEASE: if (!done_in) state_d = S_RUN;
            S_RUN:     if (press_q || pend_q || dwell_done) state_d = S_NEXT;
            S_NEXT:    state_d = S_LOAD;
            S_FAULT:   if (press_q) state_d = S_LOAD;
            default:   state_d = S_IDLE;
        endcase
    end

    // Program index, pending press, sticky error and load watchdog.
    always_comb begin
        prog_sel_d = prog_sel_q;
        if (state_q == S_NEXT) begin
            prog_sel_d = (prog_sel_q == SEL_W'(NPROG - 1)) ? '0 : prog_sel_q + 1'b1;
        end

        // RUN always leaves when pend is set, so clearing it there consumes it.
        pend_d = pend_q;
        if (state_q == S_RUN)                          pend_d = 1'b0;
        else if (press_q && (state_q != S_FAULT))      pend_d = 1'b1;

        err_d = err_q | (state_d == S_FAULT);

        load_cnt_d = '0;
        if (state_q == S_LOAD) begin
            load_cnt_d = (load_cnt_q == LOAD_W'(LOAD_TIMEOUT)) ? load_cnt_q : load_cnt_q + 1'b1;
        end
    end

    // Moore outputs decoded from registered state only.
    always_comb begin
        drive_out = (state_q == S_LOAD);
        busy      = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_RELEASE);
        prog_sel  = prog_sel_q;
        err       = err_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            dbnc_cnt_q <= '0;
            filt_q     <= 1'b0;
            press_q    <= 1'b0;
            pend_q     <= 1'b0;
            load_cnt_q <= '0;
            prog_sel_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= btn_next;
            sync2_q    <= sync1_q;
            dbnc_cnt_q <= dbnc_cnt_d;
            filt_q     <= filt_d;
            press_q    <= press_d;
            pend_q     <= pend_d;
            load_cnt_q <= load_cnt_d;
            prog_sel_q <= prog_sel_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: randomised self-checking bench for prog_sequencer.
// Expected behaviour is derived from segment arithmetic: a round-robin image
// index, load lengths set by the loader model, run lengths from dwell, pause
// and press latency. Adapts to whether PROG_SEQ_AUTO_ADVANCE_EN is defined.
module tb_prog_sequencer;
    localparam int unsigned NPROG = 3;
    localparam int unsigned DWELL = 20;
    localparam int unsigned DBNC  = 4;
    localparam int unsigned TMO   = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       pause = 1'b0;
    logic       done_in = 1'b0;
    logic       drive_out, busy, err;
    logic [1:0] prog_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int load_lat = 10;   // loader response delay; 0 means never respond
    int drv_cnt = 0;
    int exp_sel = 0;     // reference model of the image index
    logic       mon_en = 1'b0;
    logic       prev_drive = 1'b0;
    logic [1:0] prev_sel = '0;

    prog_sequencer #(
        .NPROG       (NPROG),
        .DWELL_CYCLES(DWELL),
        .DBNC_CYCLES (DBNC),
        .LOAD_TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_next (btn_next),
        .pause    (pause),
        .done_in  (done_in),
        .drive_out(drive_out),
        .prog_sel (prog_sel),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Loader model plus image-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (drive_out === 1'b1) begin
            drv_cnt = drv_cnt + 1;
            if (load_lat != 0 && drv_cnt >= load_lat) done_in = 1'b1;
        end else begin
            drv_cnt = 0;
            done_in = 1'b0;
        end
        if (mon_en && prog_sel !== prev_sel) check("sel_change_drive_low", prev_drive, 0);
        prev_drive = drive_out;
        prev_sel   = prog_sel;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 = drive_out, 1 = busy. Returns the cycle it matched, or -1.
    task automatic wait_sig(input string tag, input int which, input logic val,
                            input int budget, output int t);
        logic v;
        t = -1;
        v = 1'bx;
        for (int i = 0; i <= budget; i++) begin
            v = (which == 0) ? drive_out : busy;
            if (v === val) begin
                t = cyc;
                break;
            end
            if (i < budget) @(negedge clk);
        end
        if (t < 0) check({tag, "_reached"}, v, val);
    endtask

    // Stimulate one RUN/FAULT segment starting now; measure cycles until the
    // next load request (-1 if none within budget).
    task automatic run_seg(input string tag, input int btn_off, input int btn_len,
                           input int pause_off, input int pause_len, input int budget,
                           input int exp_run, input bit advance, input int next_lat,
                           output int tl);
        int r;
        r  = cyc;
        tl = -1;
        load_lat = next_lat;
        for (int i = 0; i < budget; i++) begin
            btn_next = (i >= btn_off) && (i < btn_off + btn_len);
            pause    = (i >= pause_off) && (i < pause_off + pause_len);
            @(negedge clk);
            if (drive_out === 1'b1) begin
                tl = cyc;
                break;
            end
        end
        btn_next = 1'b0;
        pause    = 1'b0;
        check({tag, "_run_len"}, (tl < 0) ? -1 : tl - r - 1, exp_run);
        if (advance) exp_sel = (exp_sel + 1) % NPROG;
        check({tag, "_sel"}, prog_sel, exp_sel);
    endtask

    // Follow a load that started at cycle tl through RELEASE into RUN.
    task automatic load_seg(input string tag, input int tl, input int exp_len);
        int tf, tr;
        wait_sig({tag, "_drop"}, 0, 1'b0, exp_len + 80, tf);
        check({tag, "_load_len"}, tf - tl, exp_len);
        wait_sig({tag, "_run"}, 1, 1'b0, 10, tr);
        check({tag, "_release_len"}, tr - tf, 1);
    endtask

    initial begin
        int t0, tl, tf, lat, off, np;

        // Reset state
        rst = 1'b1;
        cycles(3);
        check("rst_drive", drive_out, 0);
        check("rst_sel", prog_sel, 0);
        check("rst_busy", busy, 1);
        check("rst_err", err, 0);

        // Boot load of image 0
        load_lat = 10;
        rst = 1'b0;
        t0 = cyc;
        cycles(1);
        check("boot_drive", drive_out, 1);
        check("boot_sel", prog_sel, 0);
        load_seg("boot", t0 + 1, 10);
        exp_sel = 0;
        mon_en = 1'b1;

`ifdef PROG_SEQ_AUTO_ADVANCE_EN
        for (int k = 0; k < 4; k++) begin
            lat = $urandom_range(3, 12);
            run_seg("auto", 0, 0, 0, 0, 60, DWELL, 1'b1, lat, tl);
            load_seg("auto", tl, lat);
        end

        off = $urandom_range(2, 8);
        np  = $urandom_range(3, 9);
        run_seg("pause", 0, 0, off, np, 80, DWELL + np, 1'b1, 10, tl);
        load_seg("pause", tl, 10);

        run_seg("glitch", 5, 3, 0, 0, 60, DWELL, 1'b1, 10, tl);
        load_seg("glitch", tl, 10);

        off = $urandom_range(1, 8);
        run_seg("press", off, 10, 0, 0, 60, off + 7, 1'b1, 10, tl);
        load_seg("press", tl, 10);
        run_seg("after_press", 0, 0, 0, 0, 60, DWELL, 1'b1, 10, tl);
        load_seg("after_press", tl, 10);

        // Press landing on the dwell-expiry cycle: one advance, nothing pending
        run_seg("coincide", 13, 10, 0, 0, 60, DWELL, 1'b1, 10, tl);
        load_seg("coincide", tl, 10);
        run_seg("after_coincide", 0, 0, 0, 0, 60, DWELL, 1'b1, 10, tl);
        load_seg("after_coincide", tl, 10);
`else
        np = $urandom_range(50, 200);
        run_seg("idle", 0, 0, 0, np, 200, -1, 1'b0, 10, tl);
        check("idle_busy", busy, 0);

        run_seg("glitch", 5, 3, 0, 0, 40, -1, 1'b0, 10, tl);

        off = $urandom_range(1, 8);
        run_seg("press", off, 10, 0, 0, 40, off + 7, 1'b1, 10, tl);
        load_seg("press", tl, 10);
        run_seg("after_press", 0, 0, 0, 0, 40, -1, 1'b0, 10, tl);
`endif
        mon_en = 1'b0;

        // Press during a slow boot load is held pending: RUN lasts one cycle
        rst = 1'b1;
        cycles(3);
        load_lat = 30;
        rst = 1'b0;
        btn_next = 1'b1;
        t0 = cyc;
        cycles(10);
        btn_next = 1'b0;
        wait_sig("pend_drop", 0, 1'b0, 60, tf);
        check("pend_load_len", tf - t0 - 1, 30);
        wait_sig("pend_run", 1, 1'b0, 10, tf);
        exp_sel = 0;
        run_seg("pend", 0, 0, 0, 0, 40, 1, 1'b1, 0, tl);

        // Loader never answers: watchdog fault on image 1
        wait_sig("tmo_drop", 0, 1'b0, TMO + 40, tf);
        check("tmo_load_len", tf - tl, TMO);
        check("tmo_err", err, 1);
        check("tmo_busy", busy, 0);
        cycles(20);
        check("fault_hold_drive", drive_out, 0);
        check("fault_hold_err", err, 1);

        // Press in FAULT reloads the same image; err stays set
        run_seg("fault_press", 0, 10, 0, 0, 40, 6, 1'b0, 10, tl);
        check("reload_err", err, 1);
        load_seg("reload", tl, 10);
`ifdef PROG_SEQ_AUTO_ADVANCE_EN
        run_seg("after_fault", 0, 0, 0, 0, 60, DWELL, 1'b1, 10, tl);
        load_seg("after_fault", tl, 10);
`else
        run_seg("after_fault", 0, 0, 0, 0, 40, -1, 1'b0, 10, tl);
`endif
        check("after_fault_err", err, 1);

        // Reset in the middle of a load restarts at image 0
        run_seg("pre_rst", 2, 10, 0, 0, 40, 9, 1'b1, 30, tl);
        cycles(5);
        check("mid_load_drive", drive_out, 1);
        rst = 1'b1;
        cycles(1);
        check("rst_load_drive", drive_out, 0);
        check("rst_load_sel", prog_sel, 0);
        check("rst_load_err", err, 0);
        rst = 1'b0;
        cycles(1);
        check("restart_drive", drive_out, 1);
        check("restart_sel", prog_sel, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
